// File: rtl/btn_debouncer.sv
// Button/switch input conditioner: 2-flop synchronizers, per-channel debounce FSM, press/release strobes.
// Optional auto-repeat of btn_press while held is enabled by defining BTN_DEBOUNCER_REPEAT_EN.
module btn_debouncer #(
  parameter int CHANNELS        = 3,
  parameter int SW_WIDTH        = 9,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn_raw,
  input  logic [SW_WIDTH-1:0] sw_raw,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [SW_WIDTH-1:0] sw_sync
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("btn_debouncer: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  typedef enum logic [1:0] {RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND} state_t;

  logic [CHANNELS-1:0] btn_meta_p0, btn_sync_p1;
  logic [SW_WIDTH-1:0] sw_meta_p0;

  // Stage p0 -> p1: two-flop synchronizers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta_p0 <= '0;
      btn_sync_p1 <= '0;
      sw_meta_p0  <= '0;
      sw_sync     <= '0;
    end else begin
      btn_meta_p0 <= btn_raw;
      btn_sync_p1 <= btn_meta_p0;
      sw_meta_p0  <= sw_raw;
      sw_sync     <= sw_meta_p0;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             level_q, press_q, release_q;
    logic             level_nxt, press_nxt, release_nxt;
    logic             rpt_fire;
    logic             sync;

    assign sync = btn_sync_p1[g];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state     <= RELEASED;
        cnt       <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state     <= state_nxt;
        cnt       <= cnt_nxt;
        level_q   <= level_nxt;
        press_q   <= press_nxt;
        release_q <= release_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
        RELEASED: begin
          cnt_nxt = '0;
          if (sync) begin
            state_nxt = PRESS_PEND;
            cnt_nxt   = CNT_W'(1);
          end
        end
        PRESS_PEND: begin
          if (!sync) begin
            state_nxt = RELEASED;
            cnt_nxt   = '0;
          end else if (cnt == CNT_MAX) begin
            state_nxt = PRESSED;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        PRESSED: begin
          cnt_nxt = '0;
          if (!sync) begin
            state_nxt = RELEASE_PEND;
            cnt_nxt   = CNT_W'(1);
          end
        end
        RELEASE_PEND: begin
          if (sync) begin
            state_nxt = PRESSED;
            cnt_nxt   = '0;
          end else if (cnt == CNT_MAX) begin
            state_nxt = RELEASED;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end
      endcase
    end

    always_comb begin
      level_nxt   = (state_nxt == PRESSED) || (state_nxt == RELEASE_PEND);
      press_nxt   = ((state == PRESS_PEND) && sync && (cnt == CNT_MAX)) || rpt_fire;
      release_nxt = (state == RELEASE_PEND) && !sync && (cnt == CNT_MAX);
    end

`ifdef BTN_DEBOUNCER_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DLY = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_PER = RPT_W'(REPEAT_PERIOD);

    logic [RPT_W-1:0] rpt_cnt, rpt_cnt_nxt;
    logic             rpt_armed, rpt_armed_nxt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rpt_cnt   <= '0;
        rpt_armed <= 1'b0;
      end else begin
        rpt_cnt   <= rpt_cnt_nxt;
        rpt_armed <= rpt_armed_nxt;
      end
    end

    // Counts only held cycles in PRESSED; a pending release freezes it, leaving the pressed states clears it.
    always_comb begin
      rpt_cnt_nxt   = rpt_cnt;
      rpt_armed_nxt = rpt_armed;
      rpt_fire      = 1'b0;
      if ((state == PRESSED) && sync) begin
        if ((rpt_cnt + RPT_W'(1)) == (rpt_armed ? RPT_PER : RPT_DLY)) begin
          rpt_fire      = 1'b1;
          rpt_cnt_nxt   = '0;
          rpt_armed_nxt = 1'b1;
        end else begin
          rpt_cnt_nxt = rpt_cnt + RPT_W'(1);
        end
      end else if (!((state_nxt == PRESSED) || (state_nxt == RELEASE_PEND))) begin
        rpt_cnt_nxt   = '0;
        rpt_armed_nxt = 1'b0;
      end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    assign btn_level[g]   = level_q;
    assign btn_press[g]   = press_q;
    assign btn_release[g] = release_q;
  end

endmodule

// File: tb/tb_btn_debouncer.sv
// Scoreboard bench for btn_debouncer: run-length reference model feeds an expectation queue,
// a negedge monitor pops and compares every cycle.
module tb_btn_debouncer;
  localparam int CH  = 3;
  localparam int SW  = 9;
  localparam int DB  = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] btn_raw = '0;
  logic [SW-1:0] sw_raw = '0;
  logic [CH-1:0] btn_level, btn_press, btn_release;
  logic [SW-1:0] sw_sync;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [CH-1:0] level;
    logic [CH-1:0] press;
    logic [CH-1:0] rel;
    logic [SW-1:0] sw;
  } exp_t;

  exp_t exp_q[$];

  btn_debouncer #(
    .CHANNELS(CH), .SW_WIDTH(SW), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .sw_sync(sw_sync)
  );

  always #5 clk = ~clk;

  // Reference model: a change is accepted once the synchronized input has disagreed with the
  // accepted level for DB+1 consecutive edges; repeat counts held edges since acceptance.
  logic [CH-1:0] m_b1, m_b2, m_level;
  logic [SW-1:0] m_s1, m_s2;
  int run[CH];
  int held[CH];

  task automatic model_step();
    exp_t e;
    e = '0;
    if (rst) begin
      m_b1 = '0; m_b2 = '0; m_level = '0; m_s1 = '0; m_s2 = '0;
      for (int c = 0; c < CH; c++) begin run[c] = 0; held[c] = 0; end
    end else begin
      for (int c = 0; c < CH; c++) begin
`ifdef BTN_DEBOUNCER_REPEAT_EN
        if (m_level[c] && run[c] == 0 && m_b2[c]) begin
          held[c]++;
          if (held[c] == RD || (held[c] > RD && (held[c] - RD) % RP == 0)) e.press[c] = 1'b1;
        end
`endif
        if (m_b2[c] != m_level[c]) run[c]++;
        else run[c] = 0;
        if (run[c] == DB + 1) begin
          m_level[c] = ~m_level[c];
          run[c] = 0;
          held[c] = 0;
          if (m_level[c]) e.press[c] = 1'b1;
          else e.rel[c] = 1'b1;
        end
      end
      m_b2 = m_b1; m_b1 = btn_raw;
      m_s2 = m_s1; m_s1 = sw_raw;
    end
    e.level = m_level;
    e.sw    = m_s2;
    exp_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  task automatic cmp(input string name, input logic [SW-1:0] act, input logic [SW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (rst) e = '0;
        cmp("btn_level",   SW'(btn_level),   SW'(e.level));
        cmp("btn_press",   SW'(btn_press),   SW'(e.press));
        cmp("btn_release", SW'(btn_release), SW'(e.rel));
        cmp("sw_sync",     sw_sync,          e.sw);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset with random inputs, then release with inputs low
    for (int i = 0; i < 5; i++) begin
      btn_raw = CH'($urandom);
      sw_raw  = SW'($urandom);
      tick(1);
    end
    btn_raw = '0; sw_raw = '0; rst = 1'b0;
    tick(5);
    // Clean press on ch0
    btn_raw[0] = 1'b1;
    tick(12);
    // Short pulse on ch1, then 1-0-1 bounce settling high
    btn_raw[1] = 1'b1; tick(3);
    btn_raw[1] = 1'b0; tick(8);
    btn_raw[1] = 1'b1; tick(1);
    btn_raw[1] = 1'b0; tick(1);
    btn_raw[1] = 1'b1; tick(10);
    // Press ch2, then release ch0 and ch2 together
    btn_raw[2] = 1'b1; tick(10);
    btn_raw[0] = 1'b0; btn_raw[2] = 1'b0; tick(10);
    sw_raw = 9'h155; tick(4);
    btn_raw = '0; tick(10);
    // Reset while ch0 is pending with the button held
    btn_raw[0] = 1'b1; tick(5);
    rst = 1'b1; tick(2);
    rst = 1'b0; tick(12);
    // Long hold for auto-repeat, with a rejected release glitch near the end
    tick(25);
    btn_raw[0] = 1'b0; tick(2);
    btn_raw[0] = 1'b1; tick(10);
    btn_raw[0] = 1'b0; tick(10);
    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 7) == 0) btn_raw[c] = ~btn_raw[c];
      if ($urandom_range(0, 5) == 0) sw_raw = SW'($urandom);
      rst = ($urandom_range(0, 249) == 0);
      tick(1);
    end
    rst = 1'b0;
    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
